// File: rtl/compound_assign_pkg.sv
// compound_assign_pkg: opcode and divider state types shared by the accumulator unit
package compound_assign_pkg;
    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_MUL    = 4'd2,
        OP_DIV    = 4'd3,
        OP_MOD    = 4'd4,
        OP_AND    = 4'd5,
        OP_OR     = 4'd6,
        OP_XOR    = 4'd7,
        OP_SHL    = 4'd8,
        OP_SHR    = 4'd9,
        OP_ASL    = 4'd10,
        OP_ASR    = 4'd11,
        OP_ASSIGN = 4'd12
    } op_e;

    typedef enum logic [1:0] {DS_IDLE, DS_BUSY, DS_DONE} div_state_e;

    function automatic logic is_single_cycle(input op_e op);
        return op != OP_DIV && op != OP_MOD;
    endfunction
endpackage

// File: rtl/compound_assign_divider.sv
// compound_assign_divider: iterative unsigned restoring divider, one quotient bit per cycle
module compound_assign_divider
    import compound_assign_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);
    localparam int CNT_W = $clog2(WIDTH);

    div_state_e       r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quo, r_rem, r_div;
    logic [WIDTH:0]   w_shift, w_diff;

    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div};

    always_ff @(posedge i_clk) begin
        r_state <= i_rst ? DS_IDLE : w_next;
    end

    always_comb begin
        w_next = r_state == DS_BUSY ? (r_cnt == CNT_W'(WIDTH - 1) ? DS_DONE : DS_BUSY)
                                    : (i_start ? DS_BUSY : DS_IDLE);
    end

    always_comb begin
        o_busy = r_state == DS_BUSY;
        o_done = r_state == DS_DONE;
    end

    // A negative trial difference means the divisor did not fit: keep the shifted remainder.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_div <= '0;
        end else if (o_busy) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_rem <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
        end else if (i_start) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= i_dividend;
            r_div <= i_divisor;
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
endmodule

// File: rtl/compound_assign_unit.sv
// compound_assign_unit: accumulator bank applying z op= y per accepted request
module compound_assign_unit
    import compound_assign_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int NUM_ACC = 4,
    localparam int IDX_W   = $clog2(NUM_ACC)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_op,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [WIDTH-1:0] i_operand,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx,
    output logic [WIDTH-1:0] o_result,
    output logic             o_div_by_zero,
    output logic             o_illegal
);
    localparam logic [WIDTH-1:0] LIM = WIDTH'(WIDTH);

    logic [WIDTH-1:0] r_acc [NUM_ACC];
    logic             r_live, r_valid, r_dz, r_ill, r_div_mod;
    logic [IDX_W-1:0] r_idx, r_div_idx;
    logic [WIDTH-1:0] r_result;
    logic             w_busy, w_done, w_fire, w_start, w_dz, w_ill, w_big;
    logic [WIDTH-1:0] w_quo, w_rem, w_div_val, w_z, w_new, w_asr;
    op_e              w_op;

    assign w_op      = op_e'(i_op);
    assign o_ready   = r_live & ~w_busy;
    assign w_fire    = i_valid & o_ready;
    assign w_start   = w_fire & ~is_single_cycle(w_op) & (|i_operand);
    assign w_div_val = r_div_mod ? w_rem : w_quo;
    // A request accepted in the divider's DONE cycle must see the value being written back.
    assign w_z       = (w_done && i_idx == r_div_idx) ? w_div_val : r_acc[i_idx];
    assign w_big     = i_operand >= LIM;
    assign w_asr     = $signed(w_z) >>> i_operand;

    always_comb begin
        w_new = w_z;
        w_dz  = 1'b0;
        w_ill = 1'b0;
        case (w_op)
            OP_ADD:         w_new = w_z + i_operand;
            OP_SUB:         w_new = w_z - i_operand;
            OP_MUL:         w_new = w_z * i_operand;
            OP_DIV:         begin w_new = '1; w_dz = 1'b1; end
            OP_MOD:         w_dz = 1'b1;
            OP_AND:         w_new = w_z & i_operand;
            OP_OR:          w_new = w_z | i_operand;
            OP_XOR:         w_new = w_z ^ i_operand;
            OP_SHL, OP_ASL: w_new = w_big ? '0 : w_z << i_operand;
            OP_SHR:         w_new = w_big ? '0 : w_z >> i_operand;
            OP_ASR:         w_new = w_big ? {WIDTH{w_z[WIDTH-1]}} : w_asr;
            OP_ASSIGN:      w_new = i_operand;
            default:        w_ill = 1'b1;
        endcase
    end

    compound_assign_divider #(.WIDTH(WIDTH)) u_div (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (w_start),
        .i_dividend  (w_z),
        .i_divisor   (i_operand),
        .o_busy      (w_busy),
        .o_done      (w_done),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_ACC; k++) r_acc[k] <= '0;
            r_live    <= 1'b0;
            r_valid   <= 1'b0;
            r_dz      <= 1'b0;
            r_ill     <= 1'b0;
            r_idx     <= '0;
            r_result  <= '0;
            r_div_idx <= '0;
            r_div_mod <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_valid <= w_fire & ~w_start;
            r_dz    <= w_fire & ~w_start & w_dz;
            r_ill   <= w_fire & w_ill;
            if (w_done) r_acc[r_div_idx] <= w_div_val;
            if (w_fire & ~w_start) begin
                r_acc[i_idx] <= w_new;
                r_idx        <= i_idx;
                r_result     <= w_new;
            end
            if (w_start) begin
                r_div_idx <= i_idx;
                r_div_mod <= w_op == OP_MOD;
            end
        end
    end

    assign o_valid       = r_valid | w_done;
    assign o_idx         = w_done ? r_div_idx : r_idx;
    assign o_result      = w_done ? w_div_val : r_result;
    assign o_div_by_zero = r_dz;
    assign o_illegal     = r_ill;
endmodule

// File: tb/tb_compound_assign_unit.sv
// tb_compound_assign_unit: directed plan plus random ops checked against an arithmetic model
module tb_compound_assign_unit;
    logic       i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0;
    logic [3:0] i_op = '0;
    logic [1:0] i_idx = '0;
    logic [7:0] i_operand = '0;
    logic       o_ready, o_valid, o_div_by_zero, o_illegal;
    logic [1:0] o_idx;
    logic [7:0] o_result;
    int         n_chk = 0, n_err = 0;
    int         model [4];
    logic [7:0] last;

    compound_assign_unit #(.WIDTH(8), .NUM_ACC(4)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_op          (i_op),
        .i_idx         (i_idx),
        .i_operand     (i_operand),
        .o_valid       (o_valid),
        .o_idx         (o_idx),
        .o_result      (o_result),
        .o_div_by_zero (o_div_by_zero),
        .o_illegal     (o_illegal)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // returns {illegal, div_by_zero, value[7:0]}
    function automatic int ref_op(input int op, input int z, input int y);
        int v, dz, ill, zs;
        dz = 0; ill = 0; v = z;
        zs = z >= 128 ? z - 256 : z;
        case (op)
            0:      v = z + y;
            1:      v = z - y;
            2:      v = z * y;
            3:      if (y == 0) begin v = 255; dz = 1; end else v = z / y;
            4:      if (y == 0) dz = 1; else v = z % y;
            5:      v = z & y;
            6:      v = z | y;
            7:      v = z ^ y;
            8, 10:  v = y >= 8 ? 0 : z * (1 << y);
            9:      v = y >= 8 ? 0 : z / (1 << y);
            11:     v = y >= 8 ? (zs < 0 ? 255 : 0) : zs >>> y;
            12:     v = y;
            default: ill = 1;
        endcase
        return (v & 255) | (dz << 8) | (ill << 9);
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!o_ready && n < 50) begin @(negedge i_clk); n++; end
        check("ready_timeout", o_ready, 1'b1);
    endtask

    task automatic run(input int op, input int idx, input int y);
        int exp, lat, is_div;
        exp    = ref_op(op, model[idx], y);
        is_div = (op == 3 || op == 4) && y != 0;
        wait_ready();
        i_valid = 1'b1; i_op = op[3:0]; i_idx = idx[1:0]; i_operand = y[7:0];
        @(negedge i_clk);
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 40) begin
            check("busy_ready", o_ready, 1'b0);
            @(negedge i_clk);
            lat++;
        end
        check("latency", lat, is_div ? 9 : 1);
        check("result", o_result, exp & 255);
        check("idx", o_idx, idx);
        check("div_by_zero", o_div_by_zero, (exp >> 8) & 1);
        check("illegal", o_illegal, (exp >> 9) & 1);
        model[idx] = exp & 255;
        last = o_result;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 4; k++) model[k] = 0;
        repeat (3) @(negedge i_clk);
        check("rst_ready", o_ready, 1'b0);
        check("rst_valid", o_valid, 1'b0);
        check("rst_result", o_result, 8'h00);
        check("rst_idx", o_idx, 2'd0);
        check("rst_dz", o_div_by_zero, 1'b0);
        check("rst_ill", o_illegal, 1'b0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("ready_after_rst", o_ready, 1'b1);

        i_valid = 1'b1; i_op = 4'd0; i_idx = 2'd0; i_operand = 8'h05;
        @(negedge i_clk);
        check("b2b_valid0", o_valid, 1'b1);
        check("b2b_res0", o_result, 8'h05);
        check("b2b_ready", o_ready, 1'b1);
        @(negedge i_clk);
        check("b2b_valid1", o_valid, 1'b1);
        check("b2b_res1", o_result, 8'h0A);
        i_valid = 1'b0;
        model[0] = 10;
        run(0, 0, 'hFF); check("add_wrap", last, 8'h09);

        run(12, 1, 'hF0); run(11, 1, 2); check("asr2", last, 8'hFC);
        run(12, 1, 'hF0); run(9, 1, 2);  check("shr2", last, 8'h3C);
        run(8, 1, 9);                     check("shl9", last, 8'h00);
        run(12, 1, 'h80); run(11, 1, 9); check("asr9", last, 8'hFF);
        run(12, 1, 'h10); run(2, 1, 'h11); check("mul", last, 8'h10);

        run(12, 2, 'hC8); run(3, 2, 7); check("div", last, 8'h1C);
        run(12, 2, 'hC8); run(4, 2, 7); check("mod", last, 8'h04);

        run(12, 3, 'h1C); run(3, 3, 0); check("div0", last, 8'hFF);
        run(12, 3, 'h1C); run(4, 3, 0); check("mod0", last, 8'h1C);
        run(14, 3, 5);                  check("illegal_val", last, 8'h1C);

        run(12, 0, 'hA5); run(5, 0, 'h0F); check("and", last, 8'h05);
        run(12, 0, 'hA5); run(6, 0, 'h0F); check("or", last, 8'hAF);
        run(12, 0, 'hA5); run(7, 0, 'h0F); check("xor", last, 8'hAA);

        // requests presented while the divider is busy must be dropped
        wait_ready();
        i_valid = 1'b1; i_op = 4'd3; i_idx = 2'd2; i_operand = 8'h03;
        @(negedge i_clk);
        i_op = 4'd12; i_idx = 2'd0; i_operand = 8'h77;
        for (int k = 1; k <= 6; k++) begin
            check("drop_valid", o_valid, 1'b0);
            check("drop_ready", o_ready, 1'b0);
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        check("drop_div_valid", o_valid, 1'b1);
        check("drop_div_idx", o_idx, 2'd2);
        check("drop_div_res", o_result, 8'h01);
        model[2] = 1;
        run(6, 0, 0); check("drop_untouched", last, 8'hAA);

        // reset in the middle of a divide
        run(12, 2, 'hC8);
        wait_ready();
        i_valid = 1'b1; i_op = 4'd3; i_idx = 2'd2; i_operand = 8'h07;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("mid_rst_ready", o_ready, 1'b0);
        check("mid_rst_valid", o_valid, 1'b0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("mid_rst_ready_after", o_ready, 1'b1);
        for (int k = 0; k < 12; k++) begin
            check("abort_no_valid", o_valid, 1'b0);
            @(negedge i_clk);
        end
        for (int k = 0; k < 4; k++) model[k] = 0;
        for (int k = 0; k < 4; k++) begin
            run(6, k, 0);
            check("cleared", last, 8'h00);
        end

        for (int n = 0; n < 150; n++) begin
            int op, idx, y;
            op  = $urandom_range(0, 15);
            idx = $urandom_range(0, 3);
            y   = ($urandom % 4 == 0) ? $urandom_range(0, 10) : $urandom_range(0, 255);
            run(op, idx, y);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
